// File: rtl/wb_mailbox_slave_if.sv
// wb_mailbox_slave_if: Wishbone classic bus bundle for the byte mailbox.
// The master drives the request fields; the slave drives the response fields.
interface wb_mailbox_slave_if;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o,
        input  wb_rty_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o,
        output wb_rty_o
    );
endinterface

// File: rtl/wb_mailbox_slave.sv
// wb_mailbox_slave: Wishbone classic slave buffering byte writes in a FIFO
// drained by a valid/ready stream. Define WB_MBOX_RTY_EN to retry full writes.
module wb_mailbox_slave #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LOW_WATER  = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_mailbox_slave_if.slave wb,
    output logic              int_o,
    output logic [7:0]        m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [7:0]        sim_status_o
);

    localparam int AW = DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DN = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DN);
    localparam logic [CW-1:0] LOW_W   = CW'(LOW_WATER);

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ACK,
        RS_ERR,
        RS_RTY
    } resp_t;

    resp_t rs_q, rs_d;
    logic [31:0] rd_q, rd_d;

    logic [7:0]    mem [DN];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic       ovf_q, unf_q, irq_en_q, int_q;
    logic [7:0] sim_q;

    logic       req, wr, rd;
    logic [1:0] reg_sel;
    logic       is_data, is_stat, is_ctrl, is_sim;
    logic       lane0, empty, full;
    logic       data_wr, data_bad;
    logic       push_ok, ovf_hit, rty_hit;
    logic       pop, flush;
    logic [31:0] status_w;

    logic unused_bits;
    assign unused_bits = ^{wb.wb_dat_i[31:8],
                           wb.wb_sel_i[3:1],
                           wb.wb_adr_i[1:0]};

    assign req = wb.wb_cyc_i & wb.wb_stb_i
               & ~(wb.wb_ack_o | wb.wb_err_o | wb.wb_rty_o);
    assign wr  = req & wb.wb_we_i;
    assign rd  = req & ~wb.wb_we_i;

    assign reg_sel = wb.wb_adr_i[3:2];
    assign is_data = (reg_sel == 2'd0);
    assign is_stat = (reg_sel == 2'd1);
    assign is_ctrl = (reg_sel == 2'd2);
    assign is_sim  = (reg_sel == 2'd3);
    assign lane0   = wb.wb_sel_i[0];

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign data_wr  = wr & is_data & lane0;
    assign data_bad = wr & is_data & ~lane0;

`ifdef WB_MBOX_RTY_EN
    assign rty_hit = data_wr & full;
    assign ovf_hit = 1'b0;
`else
    assign rty_hit = 1'b0;
    assign ovf_hit = data_wr & full;
`endif
    assign push_ok = data_wr & ~full;

    assign pop   = ~empty & m_ready_i;
    assign flush = wr & is_ctrl & lane0 & wb.wb_dat_i[1];

    // Status word assembled from the current registered FIFO state.
    always_comb begin
        status_w         = '0;
        status_w[0]      = empty;
        status_w[1]      = full;
        status_w[2]      = ovf_q;
        status_w[3]      = unf_q;
        status_w[8 +: CW] = count_q;
    end

    // Response FSM next state and the read data captured with it.
    always_comb begin
        rs_d = RS_IDLE;
        rd_d = '0;
        if (data_bad) begin
            rs_d = RS_ERR;
        end else if (rty_hit) begin
            rs_d = RS_RTY;
        end else if (req) begin
            rs_d = RS_ACK;
        end
        if (rd) begin
            unique case (1'b1)
                is_data: rd_d = empty ? 32'h0
                              : {24'h0, mem[rd_ptr_q]};
                is_stat: rd_d = status_w;
                is_ctrl: rd_d = {31'h0, irq_en_q};
                is_sim:  rd_d = {24'h0, sim_q};
                default: rd_d = '0;
            endcase
        end
    end

    // Response state register; reset cancels any pending response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rs_q <= RS_IDLE;
            rd_q <= '0;
        end else begin
            rs_q <= rs_d;
            rd_q <= rd_d;
        end
    end

    assign wb.wb_ack_o = (rs_q == RS_ACK);
    assign wb.wb_err_o = (rs_q == RS_ERR);
`ifdef WB_MBOX_RTY_EN
    assign wb.wb_rty_o = (rs_q == RS_RTY);
`else
    assign wb.wb_rty_o = 1'b0;
`endif
    assign wb.wb_dat_o = wb.wb_ack_o ? rd_q : 32'h0;

    // FIFO storage; flush wins over a coincident push.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok & ~flush) begin
            mem[wr_ptr_q] <= wb.wb_dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Sticky flags, control, sim status and the level interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            sim_q    <= 8'h0;
            int_q    <= 1'b0;
        end else begin
            if (ovf_hit) begin
                ovf_q <= 1'b1;
            end else if (wr & is_stat & lane0 & wb.wb_dat_i[2]) begin
                ovf_q <= 1'b0;
            end
            if (rd & is_data & empty) begin
                unf_q <= 1'b1;
            end else if (wr & is_stat & lane0 & wb.wb_dat_i[3]) begin
                unf_q <= 1'b0;
            end
            if (wr & is_ctrl & lane0) begin
                irq_en_q <= wb.wb_dat_i[0];
            end
            if (wr & is_sim & lane0) begin
                sim_q <= wb.wb_dat_i[7:0];
            end
            int_q <= irq_en_q & (ovf_q | (count_q <= LOW_W));
        end
    end

    assign int_o        = int_q;
    assign sim_status_o = sim_q;
    assign m_valid_o    = ~empty;
    assign m_data_o     = empty ? 8'h0 : mem[rd_ptr_q];

endmodule
